// File: rtl/float16_result_queue.sv
// ---------------------------------------------------------------------------
// float16_result_queue
//
// Downstream stage of the float16 multiplier datapath. It accepts one product
// per cycle and buffers it in a DEPTH-entry FIFO. It hands entries to the
// consumer over a valid/ready handshake. It also tracks overflow status in a
// sticky flag and a saturating counter.
//
// Build option:
//   FLOAT16_RESULT_SAT_EN  when defined, an overflowed product (in_of=1) is
//                          stored as signed infinity {sign, 5'h1F, 10'h000}.
//                          When undefined, in_data is stored unchanged.
//                          The stored overflow bit always equals in_of.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   CNT_W   width of the overflow event counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over every other input)
//   in_valid   product presented on in_data / in_of
//   in_ready   queue can accept (!full)
//   in_data    float16 product {sign, exp[4:0], frac[9:0]}
//   in_of      overflow flag accompanying in_data
//   out_valid  head entry available (!empty)
//   out_ready  consumer takes the head entry
//   out_data   head entry data, 0 when empty
//   out_of     head entry overflow flag, 0 when empty
//   count      occupancy 0..DEPTH
//   of_sticky  set by any accepted entry with in_of=1
//   of_count   accepted overflowed entries, saturating at all-ones
//   clear      clears of_sticky / of_count (FIFO contents untouched)
// ---------------------------------------------------------------------------
module float16_result_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    input  logic                     in_of,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic                     out_of,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     of_sticky,
    output logic [CNT_W-1:0]         of_count,
    input  logic                     clear
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef struct packed {
        logic [15:0] data;
        logic        of_flag;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               of_push;
    logic [15:0]        store_data;

    // Handshake qualifiers. Full blocks input even when the consumer pops in
    // the same cycle, so there is no same-cycle pass-through.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign of_push   = push && in_of;

`ifdef FLOAT16_RESULT_SAT_EN
    assign store_data = in_of ? {in_data[15], 5'h1F, 10'h000} : in_data;
`else
    assign store_data = in_data;
`endif

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are live, so resetting the RAM would only cost area.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= '{data: store_data, of_flag: in_of};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tells
    // full apart from empty when the pointers are equal.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // An overflowed push in the same cycle as clear survives it: the new
    // event restarts the counter at 1 rather than being wiped.
    always_ff @(posedge clk) begin
        if (rst) begin
            of_sticky <= 1'b0;
            of_count  <= '0;
        end else if (of_push) begin
            of_sticky <= 1'b1;
            if (clear) begin
                of_count <= CNT_W'(1);
            end else if (of_count != '1) begin
                of_count <= of_count + CNT_W'(1);
            end
        end else if (clear) begin
            of_sticky <= 1'b0;
            of_count  <= '0;
        end
    end

    // Head entry is read combinationally and forced to zero when empty.
    // NOTE: every output of this block gets a default first so no latch is
    // inferred on any path.
    always_comb begin
        out_data = 16'h0000;
        out_of   = 1'b0;
        if (out_valid) begin
            out_data = mem[rd_ptr].data;
            out_of   = mem[rd_ptr].of_flag;
        end
    end

endmodule

// File: tb/tb_float16_result_queue.sv
// ---------------------------------------------------------------------------
// Self-checking bench for float16_result_queue. It drives two instances from
// the same stimulus: the default configuration (DEPTH=8, CNT_W=8) and a
// narrow-counter one (CNT_W=2), so counter saturation is exercised. Expected
// values come from a queue-based reference model that is updated once per
// clock edge.
// ---------------------------------------------------------------------------
module tb_float16_result_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_of;
    logic        out_ready;
    logic        clear;

    logic        in_ready,  in_ready_c2;
    logic        out_valid, out_valid_c2;
    logic [15:0] out_data,  out_data_c2;
    logic        out_of,    out_of_c2;
    logic [3:0]  count,     count_c2;
    logic        of_sticky, of_sticky_c2;
    logic [7:0]  of_count;
    logic [1:0]  of_count_c2;

    float16_result_queue #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_of(in_of),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_of(out_of),
        .count(count), .of_sticky(of_sticky), .of_count(of_count),
        .clear(clear)
    );

    float16_result_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_c2),
        .in_data(in_data), .in_of(in_of),
        .out_valid(out_valid_c2), .out_ready(out_ready),
        .out_data(out_data_c2), .out_of(out_of_c2),
        .count(count_c2), .of_sticky(of_sticky_c2), .of_count(of_count_c2),
        .clear(clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue of {stored_data, of}, plus status.
    logic [16:0] mq[$];
    bit          m_sticky;
    int          m_cnt8;
    int          m_cnt2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] stored_value(input logic [15:0] d, input logic of);
`ifdef FLOAT16_RESULT_SAT_EN
        if (of) return (d & 16'h8000) | 16'h7C00;
`endif
        return d;
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    // Apply one clock edge to the model using the inputs presented before it.
    task automatic model_edge(input logic r, input logic iv, input logic [15:0] d,
                              input logic of, input logic ordy, input logic clr);
        bit do_push, do_pop;
        if (r) begin
            mq.delete();
            m_sticky = 0;
            m_cnt8   = 0;
            m_cnt2   = 0;
            return;
        end
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && ordy;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({stored_value(d, of), of});
        if (do_push && of) begin
            m_sticky = 1;
            m_cnt8   = clr ? 1 : sat_inc(m_cnt8, 255);
            m_cnt2   = clr ? 1 : sat_inc(m_cnt2, 3);
        end else if (clr) begin
            m_sticky = 0;
            m_cnt8   = 0;
            m_cnt2   = 0;
        end
    endtask

    task automatic check_all(input string tag);
        bit          nonempty;
        logic [16:0] head;
        nonempty = (mq.size() != 0);
        head     = nonempty ? mq[0] : 17'h0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(nonempty));
        check({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < DEPTH));
        check({tag, ".out_data"},  32'(out_data),  32'(head[16:1]));
        check({tag, ".out_of"},    32'(out_of),    32'(head[0]));
        check({tag, ".count"},     32'(count),     32'(mq.size()));
        check({tag, ".of_sticky"}, 32'(of_sticky), 32'(m_sticky));
        check({tag, ".of_count"},  32'(of_count),  32'(m_cnt8));
        check({tag, ".c2_out_data"}, 32'(out_data_c2), 32'(head[16:1]));
        check({tag, ".c2_of_count"}, 32'(of_count_c2), 32'(m_cnt2));
    endtask

    // Drive inputs, advance one edge in DUT and model, sample 1 ns later.
    task automatic step(input string tag, input logic r, input logic iv,
                        input logic [15:0] d, input logic of,
                        input logic ordy, input logic clr);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        in_of     = of;
        out_ready = ordy;
        clear     = clr;
        model_edge(r, iv, d, of, ordy, clr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_of = 1'b0;
        out_ready = 1'b0; clear = 1'b0;
        #1;

        // Reset state
        step("reset0", 1, 0, 16'h0, 0, 0, 0);
        step("reset1", 1, 1, 16'hFFFF, 1, 1, 1);

        // Single push of 1.0, no consumer
        step("push_one", 0, 1, 16'h3C00, 0, 0, 0);
        check("push_one.count_is_1", 32'(count), 32'd1);
        step("drain_one", 0, 0, 16'h0, 0, 1, 0);

        // Fill to DEPTH, then a 9th push is refused
        for (int i = 1; i <= DEPTH; i++)
            step("fill", 0, 1, 16'(i), 0, 0, 0);
        check("full.in_ready_low", 32'(in_ready), 32'd0);
        step("ninth_ignored", 0, 1, 16'h0009, 0, 0, 0);
        // Full with out_ready: pop happens, push is still refused
        step("full_pop_no_push", 0, 1, 16'h0077, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++)
            step("drain", 0, 0, 16'h0, 0, 1, 0);
        check("drained.out_data_zero", 32'(out_data), 32'd0);

        // Continuous streaming across pointer wrap
        for (int i = 0; i < 20; i++)
            step("stream", 0, 1, 16'h1000 + 16'(i), 0, 1, 0);
        step("stream_tail", 0, 0, 16'h0, 0, 1, 0);

        // Overflowed product: saturation depends on build, status does not
        step("of_push", 0, 1, 16'hD123, 1, 0, 0);
        check("of_push.of_count_is_1", 32'(of_count), 32'd1);
        step("of_drain", 0, 0, 16'h0, 0, 1, 0);

        // Counter saturation on the narrow instance
        for (int i = 0; i < 5; i++)
            step("of_sat", 0, 1, 16'($urandom), 1, 1, 0);
        check("of_sat.c2_saturated", 32'(of_count_c2), 32'd3);
        step("of_sat_tail", 0, 0, 16'h0, 0, 1, 0);

        // Clear alone, then clear with a simultaneous overflowed push
        step("clear_alone", 0, 0, 16'h0, 0, 1, 1);
        step("clear_with_of", 0, 1, 16'h7BFF, 1, 1, 1);
        step("clear_with_of_tail", 0, 0, 16'h0, 0, 1, 0);

        // Randomized traffic with occasional clear and reset
        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(63) == 0), ($urandom_range(3) != 0),
                 16'($urandom), ($urandom_range(3) == 0),
                 ($urandom_range(2) != 0), ($urandom_range(15) == 0));
        // Bias toward a mostly-full queue
        for (int i = 0; i < 100; i++)
            step("rand_full", 0, 1, 16'($urandom), ($urandom_range(1) == 0),
                 ($urandom_range(3) == 0), 0);

        // Reset mid-stream discards contents and wins over in_valid
        step("pre_rst_clean", 1, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("pre_rst_fill", 0, 1, 16'hA000 + 16'(i), 1, 0, 0);
        step("rst_with_push", 1, 1, 16'hBEEF, 1, 0, 0);
        check("rst_with_push.count_zero", 32'(count), 32'd0);
        step("post_rst_idle", 0, 0, 16'h0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float16_result_queue.md
Name: float16_result_queue

Overview:
- Downstream stage of the float16 multiplier datapath.
- Accepts one product per cycle: the 16-bit result plus its overflow flag.
- Optionally saturates overflowed products to signed infinity, buffers them in a FIFO, and presents them to the consumer over a valid/ready handshake.
- Keeps a sticky overflow flag and a saturating overflow counter for status readback.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  product presented on in_data/in_of.
- in_ready  output  1  queue can accept; equals !full.
- in_data  input  16  float16 product {sign, exp[4:0], frac[9:0]}.
- in_of  input  1  overflow flag accompanying in_data.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer takes the head entry.
- out_data  output  16  head entry data; 16'h0000 when empty.
- out_of  output  1  overflow flag stored with the head entry; 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- of_sticky  output  1  set on any accepted entry with in_of=1.
- of_count  output  CNT_W  number of accepted overflowed entries; saturates at all-ones.
- clear  input  1  clears of_sticky and of_count; FIFO contents are unaffected.

Behaviour:
- Reset: rd_ptr=0, wr_ptr=0, count=0, of_sticky=0, of_count=0.
  - Outputs after reset: out_valid=0, in_ready=1, out_data=0, out_of=0.
  - Reset wins over all other inputs in the same cycle.
  - Reset mid-stream discards all stored entries.
- Push: occurs when in_valid && in_ready at a clock edge.
  - Stores {data', in_of} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready.
  - rd_ptr increments modulo DEPTH.
- Occupancy update: count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency:
  - An entry pushed at edge N is visible at out_valid/out_data in the cycle after edge N. There is no combinational fall-through.
  - out_data and out_of are read combinationally from mem[rd_ptr] and gated to 0 when empty.
- Full (count==DEPTH):
  - in_ready=0, even if out_ready=1 in the same cycle; there is no same-cycle pass-through.
  - A pop frees a slot for the next cycle.
- Empty (count==0):
  - out_valid=0.
  - A simultaneous in_valid fills the queue; no pop occurs that cycle.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap silently; count distinguishes full from empty.
- Overflow status, per pushed entry with in_of=1:
  - of_sticky becomes 1 at that edge.
  - of_count increments unless it is already all-ones.
  - Entries with in_of=0 have no effect on status.
- Clear:
  - clear=1 with no overflowed push: of_sticky=0 and of_count=0 at the next edge.
  - clear=1 with an overflowed push in the same cycle: of_sticky=1 and of_count=1 (the new event survives the clear).
- Handshake rules:
  - Upstream must hold in_data/in_of stable while in_valid && !in_ready.
  - The queue holds out_data stable while out_valid && !out_ready.

Optional Feature:
- Macro: FLOAT16_RESULT_SAT_EN.
- Defined: when in_of=1, data' = {in_data[15], 5'h1F, 10'h000}, i.e. signed infinity.
- Undefined: data' = in_data unchanged.
- In both builds the stored out_of bit equals in_of.
- Status logic is identical in both builds.

Test Plan:
- Reset, then push 16'h3C00 (1.0) with in_of=0 and out_ready=0 -> next cycle out_valid=1, out_data=16'h3C00, out_of=0, count=1, of_sticky=0.
- Push DEPTH=8 entries 16'h0001..16'h0008 with out_ready=0 -> after the 8th edge count=8 and in_ready=0. A 9th in_valid is ignored. Draining then yields 0001..0008 in order, after which out_valid=0 and out_data=0.
- Hold in_valid=1 and out_ready=1 continuously for 20 cycles with incrementing data -> one entry per cycle, count stays 1 after the first push, data is in order across pointer wrap.
- Push in_data=16'hD123 with in_of=1:
  - SAT_EN build -> out_data=16'hFC00, out_of=1.
  - Non-SAT build -> out_data=16'hD123, out_of=1.
  - Both builds -> of_sticky=1, of_count=1.
- With CNT_W=2, push 5 overflowed entries -> of_count stays 3. Assert clear alone -> of_count=0, of_sticky=0. Assert clear together with an overflowed push -> of_count=1, of_sticky=1.
- Fill 3 entries, assert rst for one cycle together with in_valid=1 -> count=0, out_valid=0, in_ready=1, and no entry is written.
